// File: rtl/serpar_pkg.sv
// Shared definitions for the byte-serial/parallel buffer sequencer.
// State encoding, default operation size and byte width.
package serpar_pkg;

  localparam int NBYTES_DEF = 112;
  localparam int BYTE_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_CAPT  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  function automatic logic strobe_onehot0(input logic wr, input logic rd, input logic en);
    return ({1'b0, wr} + {1'b0, rd} + {1'b0, en}) <= 2'd1;
  endfunction

endpackage

// File: rtl/serpar_seq_ctrl_if.sv
// Handshake, buffer-strobe and core-control bundle of the serpar sequencer.
// master = sequencer side, slave = buffer/core/stream partner side.
interface serpar_seq_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic buf_wr;
  logic buf_rd;
  logic buf_en;
  logic core_start;
  logic core_done;
  logic busy;
  logic err;

  modport master (
    input  in_valid, out_ready, core_done,
    output in_ready, out_valid, buf_wr, buf_rd, buf_en, core_start, busy, err
  );

  modport slave (
    output in_valid, out_ready, core_done,
    input  in_ready, out_valid, buf_wr, buf_rd, buf_en, core_start, busy, err
  );
endinterface

// File: rtl/serpar_byte_cnt.sv
// Modulo-NBYTES byte counter shared by the fill and drain phases.
// last flags cnt==NBYTES-1; an increment on last wraps to zero.
module serpar_byte_cnt #(
  parameter int NBYTES = 112,
  parameter int CNT_W  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(NBYTES - 1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  assign last = (cnt_q == LAST_VAL);
  assign cnt  = cnt_q;

  // next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc) begin
      if (last) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serpar_seq_ctrl.sv
// Sequencer for the serial/parallel I/O buffer around the SKINNY core: fill, start, wait, capture, drain.
// Optional WAIT timeout with sticky err is compiled in with SERPAR_TIMEOUT_EN.
module serpar_seq_ctrl
  import serpar_pkg::*;
#(
  parameter int NBYTES  = NBYTES_DEF,
  parameter int CNT_W   = 7,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  serpar_seq_ctrl_if.master bus
);

  state_t state_d;
  state_t state_q;

  logic in_ready_s;
  logic out_valid_s;
  logic buf_wr_s;
  logic buf_rd_s;
  logic buf_en_s;
  logic core_start_s;
  logic cnt_inc_s;
  logic cnt_clr_s;
  logic cnt_last_s;
  logic [CNT_W-1:0] cnt_s;

`ifdef SERPAR_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] tmr_d;
  logic [TMR_W-1:0] tmr_q;
  logic             err_d;
  logic             err_q;
`endif

  serpar_byte_cnt #(
    .NBYTES (NBYTES),
    .CNT_W  (CNT_W)
  ) u_byte_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (cnt_inc_s),
    .clr  (cnt_clr_s),
    .cnt  (cnt_s),
    .last (cnt_last_s)
  );

  // next state and strobes; IDLE and FILL share acceptance so NBYTES==1 skips FILL
  always_comb begin
    state_d      = state_q;
    in_ready_s   = 1'b0;
    out_valid_s  = 1'b0;
    buf_wr_s     = 1'b0;
    buf_rd_s     = 1'b0;
    buf_en_s     = 1'b0;
    core_start_s = 1'b0;
    cnt_inc_s    = 1'b0;
    cnt_clr_s    = 1'b0;
`ifdef SERPAR_TIMEOUT_EN
    tmr_d        = tmr_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE, S_FILL: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          buf_wr_s  = 1'b1;
          cnt_inc_s = 1'b1;
          state_d   = cnt_last_s ? S_START : S_FILL;
        end else begin
          state_d   = state_q;
        end
      end
      S_START: begin
        core_start_s = 1'b1;
        cnt_clr_s    = 1'b1;
`ifdef SERPAR_TIMEOUT_EN
        tmr_d        = {TMR_W{1'b0}};
`endif
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (bus.core_done) begin
          state_d = S_CAPT;
`ifdef SERPAR_TIMEOUT_EN
        end else if (tmr_q == TMR_LAST) begin
          err_d     = 1'b1;
          cnt_clr_s = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmr_d     = tmr_q + TMR_W'(1);
          state_d   = S_WAIT;
`else
        end else begin
          state_d = S_WAIT;
`endif
        end
      end
      S_CAPT: begin
        buf_en_s = 1'b1;
        state_d  = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid_s = 1'b1;
        if (bus.out_ready) begin
          buf_rd_s  = 1'b1;
          cnt_inc_s = 1'b1;
          state_d   = cnt_last_s ? S_IDLE : S_DRAIN;
        end else begin
          state_d   = S_DRAIN;
        end
      end
      default: begin
        cnt_clr_s = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef SERPAR_TIMEOUT_EN
  // WAIT cycle counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= {TMR_W{1'b0}};
      err_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.buf_wr     = buf_wr_s;
  assign bus.buf_rd     = buf_rd_s;
  assign bus.buf_en     = buf_en_s;
  assign bus.core_start = core_start_s;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serpar_seq_ctrl.sv
// Scoreboard bench for serpar_seq_ctrl: a byte-buffer model with an echoing core checks
// every drained byte; directed phases cover fill, gaps, backpressure, reset, random traffic and timeout.
module tb_serpar_seq_ctrl;
  import serpar_pkg::*;

  localparam int NB = 112;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] din = 8'd0;

  always #5 clk = ~clk;

  serpar_seq_ctrl_if bus ();

  serpar_seq_ctrl #(
    .NBYTES  (NB),
    .CNT_W   (7),
    .TIMEOUT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int en_cnt = 0;
  logic start_prev = 1'b0;
  logic [7:0] model [NB];
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: strobe rules, buffer model, and scoreboard pop on every output handshake
  always @(negedge clk) begin
    if (!rst) begin
      chk("strobe_onehot", int'({bus.buf_wr, bus.buf_rd, bus.buf_en} inside {3'b000, 3'b001, 3'b010, 3'b100}), 1);
      chk("wr_is_in_hs", int'(bus.buf_wr), int'(bus.in_valid & bus.in_ready));
      chk("rd_is_out_hs", int'(bus.buf_rd), int'(bus.out_valid & bus.out_ready));
      chk("start_single", int'(start_prev & bus.core_start), 0);
      start_prev = bus.core_start;
      if (bus.buf_wr) begin
        for (int i = 0; i < NB - 1; i++) model[i] = model[i+1];
        model[NB-1] = din;
        wr_cnt++;
      end
      if (bus.buf_en) en_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        chk("out_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("data_out", int'(model[0]), int'(exp_q.pop_front()));
      end
      if (bus.buf_rd) begin
        for (int i = 0; i < NB - 1; i++) model[i] = model[i+1];
        model[NB-1] = 8'd0;
        rd_cnt++;
      end
    end else begin
      start_prev = 1'b0;
    end
  end

  task automatic fill(input int n, input bit gapped, input bit expect_start);
    int got = 0;
    int cyc = 0;
    int early = 0;
    int w0 = wr_cnt;
    step();
    while (got < n && cyc < 4 * NB) begin
      bus.in_valid = gapped ? (cyc % 2 == 0) : 1'b1;
      din = 8'(got + 1);
      @(negedge clk);
      early += int'(bus.core_start);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(din);
        got++;
      end
      step();
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("fill_accepted", got, n);
    chk("fill_no_early_start", early, 0);
    if (expect_start) begin
      @(negedge clk);
      chk("start_latency", int'(bus.core_start), 1);
      chk("start_in_ready", int'(bus.in_ready), 0);
      chk("fill_wr_pulses", wr_cnt - w0, n);
    end
  endtask

  task automatic core(input int delay);
    int e0 = en_cnt;
    repeat (delay) step();
    @(negedge clk);
    chk("wait_busy", int'(bus.busy), 1);
    step();
    bus.core_done = 1'b1;
    @(negedge clk);
    chk("en_not_yet", int'(bus.buf_en), 0);
    step();
    bus.core_done = 1'b0;
    @(negedge clk);
    chk("done_to_en", int'(bus.buf_en), 1);
    chk("capt_out_valid", int'(bus.out_valid), 0);
    step();
    @(negedge clk);
    chk("en_to_valid", int'(bus.out_valid), 1);
    chk("drain_in_ready", int'(bus.in_ready), 0);
    chk("en_pulses", en_cnt - e0, 1);
  endtask

  task automatic drain(input int bp_at, input int bp_len);
    int cyc = 0;
    int rd0 = rd_cnt;
    step();
    while (exp_q.size() > 0 && cyc < 1000) begin
      bus.out_ready = !(cyc >= bp_at && cyc < bp_at + bp_len);
      @(negedge clk);
      if (!bus.out_ready) begin
        chk("bp_valid_held", int'(bus.out_valid), 1);
        chk("bp_no_rd", int'(bus.buf_rd), 0);
      end
      step();
      cyc++;
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("drain_queue_empty", int'(exp_q.size()), 0);
    chk("valid_drops", int'(bus.out_valid), 0);
    chk("busy_drops", int'(bus.busy), 0);
    chk("rd_pulses", rd_cnt - rd0, NB);
  endtask

  task automatic pulse_reset();
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.core_done = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
  endtask

  task automatic random_traffic(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      step();
      bus.in_valid  = 1'($urandom_range(0, 1));
      din           = 8'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.core_done = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) exp_q.push_back(din);
    end
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.core_done = 1'b0;
  endtask

  initial begin
    int e0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.core_done = 1'b0;
    for (int i = 0; i < NB; i++) model[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_err", int'(bus.err), 0);
    chk("reset_strobes", int'({bus.buf_wr, bus.buf_rd, bus.buf_en, bus.core_start}), 0);

    // continuous fill, 20-cycle core, continuous drain
    fill(NB, 1'b0, 1'b1);
    core(20);
    drain(1000, 0);

    // gapped input
    fill(NB, 1'b1, 1'b1);
    core(3);
    drain(1000, 0);

    // output backpressure mid-drain
    fill(NB, 1'b0, 1'b1);
    core(0);
    drain(40, 5);

    // reset in the middle of a fill, then a clean operation
    fill(50, 1'b0, 1'b0);
    pulse_reset();
    fill(NB, 1'b0, 1'b1);
    core(5);
    drain(10, 3);

    // random valid/ready/done traffic
    random_traffic(1200);

    // core never answers
    pulse_reset();
    fill(NB, 1'b0, 1'b1);
    e0 = en_cnt;
    repeat (40) step();
    @(negedge clk);
`ifdef SERPAR_TIMEOUT_EN
    chk("timeout_err", int'(bus.err), 1);
    chk("timeout_idle", int'(bus.busy), 0);
`else
    chk("no_timeout_err", int'(bus.err), 0);
    chk("no_timeout_busy", int'(bus.busy), 1);
`endif
    chk("timeout_no_en", en_cnt - e0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
